addressdecode_irq_arb: RTL

- Next-generation Dock interrupt router.
- Generalises slot interrupt channel count.
- Synchronises all slot and CPU interrupt inputs.
- Stretches NMI into fixed-width pulses.
- Replaces unique-claimant-only Mode-2 acknowledge with a registered acknowledge state machine: per-channel round-robin arbitration among multiple claimants, grant latched for the whole acknowledge cycle, and timeout recovery.
- Sits between slot connectors and the CPU-card interrupt/acknowledge pins.

---
 rtl/addressdecode_irq_arb.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/addressdecode_irq_arb.sv
// Dock interrupt router: synchronises slot/CPU interrupt lines, merges slot INT
// channels onto CPU INT, stretches NMI, and arbitrates Mode-2 acknowledge cycles.
module addressdecode_irq_arb #(
    parameter int NUM_IRQ_SLOTS  = 4,
    parameter int SLOT_INT_LINES = 2,
    parameter int HOST_INT_LINES = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int NMI_PULSE      = 8,
    parameter int ACK_TIMEOUT    = 255,
    localparam int CW = (SLOT_INT_LINES > 1) ? $clog2(SLOT_INT_LINES) : 1,
    localparam int SW = (NUM_IRQ_SLOTS > 1) ? $clog2(NUM_IRQ_SLOTS) : 1,
    localparam int NI = NUM_IRQ_SLOTS * SLOT_INT_LINES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NI-1:0]             slot_int_n,
    input  logic [NUM_IRQ_SLOTS-1:0]  slot_nmi_n,
    input  logic [SLOT_INT_LINES-1:0] cpu_ack_n,
    input  logic                      int_ack_mode_en,
    output logic [HOST_INT_LINES-1:0] cpu_int_n,
    output logic [1:0]                cpu_nmi_n,
    output logic [NI-1:0]             slot_int_ack_n,
    output logic                      ack_cycle,
    output logic [CW-1:0]             ack_chan,
    output logic [SW-1:0]             ack_slot,
    output logic                      ack_slot_valid,
    output logic                      ack_timeout
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int NW = $clog2(NMI_PULSE + 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACTIVE   = 2'd1;
    localparam logic [1:0] NOCLAIM  = 2'd2;
    localparam logic [1:0] WAIT_REL = 2'd3;

    logic [SYNC_STAGES-1:0][NI-1:0]             int_sync;
    logic [SYNC_STAGES-1:0][NUM_IRQ_SLOTS-1:0]  nmi_sync;
    logic [SYNC_STAGES-1:0][SLOT_INT_LINES-1:0] ack_sync;
    logic [NI-1:0]             sint;
    logic [NUM_IRQ_SLOTS-1:0]  snmi;
    logic [SLOT_INT_LINES-1:0] sack;

    // NOTE: synchroniser flops reset to 1 so an idle (high) active-low line
    // cannot look asserted during the first cycles after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_sync <= '1;
            nmi_sync <= '1;
            ack_sync <= '1;
        end else begin
            int_sync <= {int_sync[SYNC_STAGES-2:0], slot_int_n};
            nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], slot_nmi_n};
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], cpu_ack_n};
        end
    end

    assign sint = int_sync[SYNC_STAGES-1];
    assign snmi = nmi_sync[SYNC_STAGES-1];
    assign sack = ack_sync[SYNC_STAGES-1];

    logic [HOST_INT_LINES-1:0] int_and;

    // NOTE: always_comb uses blocking assignments and gives every variable a
    // default first, so no latch can be inferred.
    always_comb begin
        int_and = '1;
        for (int c = 0; c < SLOT_INT_LINES; c++) begin
            for (int s = 0; s < NUM_IRQ_SLOTS; s++) begin
                int_and[c] = int_and[c] & sint[s*SLOT_INT_LINES + c];
            end
        end
    end

    // NOTE: sequential state always uses non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cpu_int_n <= '1;
        else        cpu_int_n <= int_and;
    end

    logic          nmi_any;
    logic          nmi_prev;
    logic [NW-1:0] nmi_cnt;

    assign nmi_any = &snmi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_prev <= 1'b1;
            nmi_cnt  <= '0;
        end else begin
            nmi_prev <= nmi_any;
            if (nmi_prev && !nmi_any) nmi_cnt <= NW'(NMI_PULSE);
            else if (nmi_cnt != '0)   nmi_cnt <= nmi_cnt - 1'b1;
        end
    end

    assign cpu_nmi_n = (nmi_cnt != '0) ? 2'b00 : 2'b11;

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [SW-1:0] last_grant [SLOT_INT_LINES];
    logic          req_any;
    logic [CW-1:0] req_chan;
    logic          found;
    logic [SW-1:0] grant_slot;
    logic [NI-1:0] grant_mask;

    always_comb begin
        req_any  = ~&sack;
        req_chan = '0;
        for (int c = SLOT_INT_LINES - 1; c >= 0; c--) begin
            if (!sack[c]) req_chan = CW'(c);
        end
    end

    // Round-robin: scan from the slot after the last grant on this channel.
    always_comb begin
        found      = 1'b0;
        grant_slot = '0;
        for (int i = 1; i <= NUM_IRQ_SLOTS; i++) begin : scan
            int idx;
            idx = (int'(last_grant[req_chan]) + i) % NUM_IRQ_SLOTS;
            if (!found && !sint[idx*SLOT_INT_LINES + int'(req_chan)]) begin
                found      = 1'b1;
                grant_slot = SW'(idx);
            end
        end
        grant_mask = ~(NI'(1) << (int'(grant_slot)*SLOT_INT_LINES + int'(req_chan)));
    end

    // NOTE: last_grant is a small register array, not RAM, so it is reset
    // explicitly; this defines the first winner on every channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            timer          <= '0;
            ack_cycle      <= 1'b0;
            ack_chan       <= '0;
            ack_slot       <= '0;
            ack_slot_valid <= 1'b0;
            ack_timeout    <= 1'b0;
            slot_int_ack_n <= '1;
            for (int c = 0; c < SLOT_INT_LINES; c++) begin
                last_grant[c] <= SW'(NUM_IRQ_SLOTS - 1);
            end
        end else begin
            ack_timeout <= 1'b0;
            if (state == IDLE) begin
                if (int_ack_mode_en && req_any) begin
                    ack_chan  <= req_chan;
                    ack_cycle <= 1'b1;
                    timer     <= '0;
                    if (found) begin
                        state          <= ACTIVE;
                        ack_slot       <= grant_slot;
                        ack_slot_valid <= 1'b1;
                        slot_int_ack_n <= grant_mask;
                    end else begin
                        state          <= NOCLAIM;
                        ack_slot       <= '0;
                        ack_slot_valid <= 1'b0;
                    end
                end
            end else if (!int_ack_mode_en || sack[ack_chan]) begin
                // Mode-disable wins over release; only a clean release advances the rotation.
                if (int_ack_mode_en && state == ACTIVE) last_grant[ack_chan] <= ack_slot;
                state          <= IDLE;
                ack_cycle      <= 1'b0;
                ack_slot_valid <= 1'b0;
                slot_int_ack_n <= '1;
            end else if (state != WAIT_REL) begin
                if (timer == TW'(ACK_TIMEOUT - 1)) begin
                    state          <= WAIT_REL;
                    ack_cycle      <= 1'b0;
                    ack_slot_valid <= 1'b0;
                    slot_int_ack_n <= '1;
                    ack_timeout    <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

endmodule
